// File: rtl/variable_shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// variable_shift_pkg
// Shared types and packet field helpers for the variable shift pipeline.
// A packet is laid out MSB-first as {cfg flag, addr, payload}.
// Contents:
//   shift_mode_e  - shift mode encoding (SLL, SRL, SRA, ROL)
//   msg_width()   - total packet width for a given addr/payload size
//   cfg_pos()     - bit index of the cfg flag
//   addr_lo()     - lowest bit index of the addr field
//   shamt_width() - width of the shift-amount field for a payload size
// -----------------------------------------------------------------------------
package variable_shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_mode_e;

  function automatic int msg_width(input int addr_size, input int payload_size);
    return addr_size + payload_size + 1;
  endfunction

  function automatic int cfg_pos(input int addr_size, input int payload_size);
    return addr_size + payload_size;
  endfunction

  function automatic int addr_lo(input int payload_size);
    return payload_size;
  endfunction

  function automatic int shamt_width(input int payload_size);
    return $clog2(payload_size);
  endfunction

endpackage

// File: rtl/variable_shift_pipe_if.sv
// -----------------------------------------------------------------------------
// variable_shift_pipe_if
// Valid/ready packet stream carrying one {cfg, addr, payload} message.
// Signals:
//   msg - packet, MSG_W bits
//   val - msg is valid this cycle
//   rdy - receiver can take msg this cycle
// Modports:
//   master - producer side (drives msg/val, observes rdy)
//   slave  - consumer side (observes msg/val, drives rdy)
// -----------------------------------------------------------------------------
interface variable_shift_pipe_if #(
  parameter int MSG_W = 13
);

  logic [MSG_W-1:0] msg;
  logic             val;
  logic             rdy;

  modport master (output msg, output val, input rdy);
  modport slave  (input msg, input val, output rdy);

endinterface

// File: rtl/variable_shift_unit.sv
// -----------------------------------------------------------------------------
// variable_shift_unit
// Purely combinational payload shifter.
// Ports:
//   payload - input word, PAYLOAD_SIZE bits
//   shamt   - shift amount, $clog2(PAYLOAD_SIZE) bits
//   mode    - SLL / SRL (zero fill), SRA (sign fill), ROL (rotate left)
//   result  - shifted word, truncated to PAYLOAD_SIZE bits
// Shift amounts at or beyond the width (only reachable for non-power-of-two
// widths) give 0 for SLL/SRL, all sign bits for SRA, and wrap for ROL.
// -----------------------------------------------------------------------------
module variable_shift_unit
  import variable_shift_pkg::*;
#(
  parameter int PAYLOAD_SIZE = 8,
  localparam int SHAMT_W = shamt_width(PAYLOAD_SIZE)
) (
  input  logic [PAYLOAD_SIZE-1:0] payload,
  input  logic [SHAMT_W-1:0]      shamt,
  input  shift_mode_e             mode,
  output logic [PAYLOAD_SIZE-1:0] result
);

  function automatic logic [PAYLOAD_SIZE-1:0] rotate_left(
    input logic [PAYLOAD_SIZE-1:0] word,
    input logic [SHAMT_W-1:0]      amt
  );
    logic [SHAMT_W-1:0]        rot_amt;
    logic [2*PAYLOAD_SIZE-1:0] doubled;
    rot_amt = SHAMT_W'(int'(amt) % PAYLOAD_SIZE);
    // Shifting a doubled copy left leaves the rotated word in the upper half.
    doubled = {word, word} << rot_amt;
    return doubled[2*PAYLOAD_SIZE-1:PAYLOAD_SIZE];
  endfunction

  logic signed [PAYLOAD_SIZE-1:0] payload_s;
  logic signed [PAYLOAD_SIZE-1:0] sra_s;

  assign payload_s = payload;
  assign sra_s     = payload_s >>> shamt;

  always_comb begin
    result = payload;
    case (mode)
      SLL:     result = payload << shamt;
      SRL:     result = payload >> shamt;
      SRA:     result = sra_s;
      ROL:     result = rotate_left(payload, shamt);
      default: result = payload;
    endcase
  end

endmodule

// File: rtl/variable_shift_pipe.sv
// -----------------------------------------------------------------------------
// variable_shift_pipe
// Two-stage valid/ready payload shifter for the packet-routing interconnect.
// Data packets (cfg=0) leave with their payload shifted by the configured
// amount/mode; header is untouched. Config packets addressed to CONFIG_ADDR
// are consumed and update the configuration; config packets for other
// addresses pass through unmodified.
// Ports:
//   clk       - clock
//   reset     - asynchronous active-high reset
//   recv      - inbound packet stream (slave)
//   send      - outbound packet stream (master), driven straight from stage 2
//   cfg_shamt - current shift amount
//   cfg_mode  - current mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL
// -----------------------------------------------------------------------------
module variable_shift_pipe
  import variable_shift_pkg::*;
#(
  parameter int                  ADDR_SIZE    = 4,
  parameter int                  PAYLOAD_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] CONFIG_ADDR = '0,
  localparam int SHAMT_W = shamt_width(PAYLOAD_SIZE),
  localparam int MSG_W   = msg_width(ADDR_SIZE, PAYLOAD_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  variable_shift_pipe_if.slave  recv,
  variable_shift_pipe_if.master send,
  output logic [SHAMT_W-1:0]  cfg_shamt,
  output logic [1:0]          cfg_mode
);

  localparam int CFG_POS = cfg_pos(ADDR_SIZE, PAYLOAD_SIZE);
  localparam int ADDR_LO = addr_lo(PAYLOAD_SIZE);

  // Configuration registers
  logic [SHAMT_W-1:0] cfg_shamt_q;
  shift_mode_e        cfg_mode_q;

  // Stage 1: accepted packet plus config snapshot
  logic               vld_p1;
  logic [MSG_W-1:0]   msg_p1;
  logic [SHAMT_W-1:0] shamt_p1;
  shift_mode_e        mode_p1;

  // Stage 2: output register
  logic               vld_p2;
  logic [MSG_W-1:0]   msg_p2;

  logic adv_p1;
  logic adv_p2;
  logic take;
  logic own_cfg;
  logic cfg_take;
  logic data_take;

  logic [PAYLOAD_SIZE-1:0] shifted_p1;
  logic [MSG_W-1:0]        msg_next_p2;

  // Each stage may advance when it is empty or the stage after it drains.
  assign adv_p2   = !vld_p2 || send.rdy;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign recv.rdy = adv_p1;

  assign take      = recv.val && recv.rdy;
  assign own_cfg   = recv.msg[CFG_POS] && (recv.msg[CFG_POS-1:ADDR_LO] == CONFIG_ADDR);
  assign cfg_take  = take && own_cfg;
  // Own config packets are absorbed here and never occupy a stage.
  assign data_take = take && !own_cfg;

  variable_shift_unit #(
    .PAYLOAD_SIZE(PAYLOAD_SIZE)
  ) u_shift (
    .payload(msg_p1[PAYLOAD_SIZE-1:0]),
    .shamt  (shamt_p1),
    .mode   (mode_p1),
    .result (shifted_p1)
  );

  // Foreign config packets reach stage 2 untouched; only data is shifted.
  assign msg_next_p2 = msg_p1[CFG_POS] ? msg_p1
                                       : {msg_p1[MSG_W-1:PAYLOAD_SIZE], shifted_p1};

  // ---- config registers and stage valids ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_shamt_q <= '0;
      cfg_mode_q  <= SLL;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
    end else begin
      if (cfg_take) begin
        cfg_shamt_q <= recv.msg[SHAMT_W-1:0];
        cfg_mode_q  <= shift_mode_e'(recv.msg[SHAMT_W+1:SHAMT_W]);
      end
      if (adv_p2) begin
        vld_p2 <= vld_p1;
      end
      if (adv_p1) begin
        vld_p1 <= data_take;
      end
    end
  end

  // ---- stage 1 capture: packet and config snapshot ----
  always_ff @(posedge clk) begin
    if (adv_p1 && data_take) begin
      msg_p1   <= recv.msg;
      shamt_p1 <= cfg_shamt_q;
      mode_p1  <= cfg_mode_q;
    end
  end

  // ---- stage 1 -> stage 2: shifted packet, cleared on reset ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_p2 <= '0;
    end else if (adv_p2 && vld_p1) begin
      msg_p2 <= msg_next_p2;
    end
  end

  assign send.msg  = msg_p2;
  assign send.val  = vld_p2;
  assign cfg_shamt = cfg_shamt_q;
  assign cfg_mode  = cfg_mode_q;

endmodule
